mips_stage_controller: RTL and testbench

Multi-cycle sequencer for the MIPS core. It owns the program counter and the five-stage step sequence (fetch, decode, execute, memory, writeback), and drives a one-hot stage enable to the fetch, decode, ALU, memory and write-back blocks. It stalls on data-memory handshakes, applies branch offsets with instruction-memory wrap-around, halts on end-of-program, and counts retired instructions.

---
 rtl/mips_stage_controller.sv | 186 ++++++++++++++++++
 tb/tb_mips_stage_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_stage_controller.sv
// mips_stage_controller
// Multi-cycle sequencer for the MIPS core. It owns the program counter and
// walks every instruction through FETCH, DECODE, EXECUTE, MEMORY and
// WRITEBACK. It stalls in MEMORY until the data memory acknowledges, and
// applies branch offsets modulo IMEM_DEPTH. It halts on end-of-program and
// keeps a saturating count of retired instructions.
//
// Optional feature macro: STAGE_SKIP_EN
//   defined   : EXECUTE jumps straight to WRITEBACK when the instruction
//               requests no data-memory access.
//   undefined : every instruction spends at least one cycle in MEMORY.
//
// Every output comes from a flop. stage_en is registered from the next state
// and the run input sampled at the same edge. As a result, stage_en reads 0
// in any cycle that follows a frozen (run=0) edge.
module mips_stage_controller #(
    parameter int PC_WIDTH   = 4,
    parameter int IMEM_DEPTH = 9,
    parameter int RESET_PC   = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic                branch,
    input  logic                zero,
    input  logic [31:0]         branch_offset,
    input  logic                end_program,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic                mem_ready,
    output logic [PC_WIDTH-1:0] pc,
    output logic [2:0]          stage,
    output logic [4:0]          stage_en,
    output logic                halted,
    output logic [15:0]         retired
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } stage_t;

    localparam logic signed [33:0]   DEPTH_S    = 34'(IMEM_DEPTH);
    localparam logic [PC_WIDTH-1:0]  RESET_PC_V = PC_WIDTH'(RESET_PC);

    // The sum is formed at 34 bits so that pc + 1 + a full 32-bit signed
    // offset can never overflow. Negative remainders are folded back into
    // the range [0, IMEM_DEPTH-1].
    function automatic logic [PC_WIDTH-1:0] next_pc(
        input logic [PC_WIDTH-1:0] cur,
        input logic                take,
        input logic [31:0]         off
    );
        logic signed [33:0] ext_v;
        logic signed [33:0] sum_v;
        logic signed [33:0] mod_v;
        logic signed [33:0] wrap_v;
        ext_v  = take ? $signed({{2{off[31]}}, off}) : 34'sd0;
        sum_v  = $signed({{(34-PC_WIDTH){1'b0}}, cur}) + 34'sd1 + ext_v;
        mod_v  = sum_v % DEPTH_S;
        wrap_v = (mod_v < 34'sd0) ? (mod_v + DEPTH_S) : mod_v;
        return wrap_v[PC_WIDTH-1:0];
    endfunction

    // HALT and the unreachable codes drive no enable.
    function automatic logic [4:0] stage_onehot(input stage_t st);
        case (st)
            FETCH:     return 5'b00001;
            DECODE:    return 5'b00010;
            EXECUTE:   return 5'b00100;
            MEMORY:    return 5'b01000;
            WRITEBACK: return 5'b10000;
            default:   return 5'b00000;
        endcase
    endfunction

    stage_t                stage_r;
    stage_t                stage_s;
    logic [PC_WIDTH-1:0]   pc_r;
    logic [PC_WIDTH-1:0]   pc_s;
    logic [15:0]           retired_r;
    logic [15:0]           retired_s;
    logic                  taken_r;
    logic                  taken_s;
    logic [31:0]           offset_r;
    logic [31:0]           offset_s;
    logic [4:0]            stage_en_r;
    logic [4:0]            stage_en_s;
    logic                  halted_r;
    logic                  halted_s;
    logic                  mem_access_s;

    // A read and a write in the same instruction count as one access.
    assign mem_access_s = mem_read | mem_write;

    // Next-state, pc, retire-count and branch-latch computation.
    always_comb begin
        stage_s   = stage_r;
        pc_s      = pc_r;
        retired_s = retired_r;
        taken_s   = taken_r;
        offset_s  = offset_r;
        if (run) begin
            case (stage_r)
                FETCH: begin
                    stage_s = DECODE;
                end
                DECODE: begin
                    if (end_program) begin
                        stage_s = HALT;
                    end else begin
                        stage_s = EXECUTE;
                    end
                end
                EXECUTE: begin
                    taken_s  = branch & zero;
                    offset_s = branch_offset;
`ifdef STAGE_SKIP_EN
                    if (mem_access_s) begin
                        stage_s = MEMORY;
                    end else begin
                        stage_s = WRITEBACK;
                    end
`else
                    stage_s = MEMORY;
`endif
                end
                MEMORY: begin
                    if (mem_access_s && !mem_ready) begin
                        stage_s = MEMORY;
                    end else begin
                        stage_s = WRITEBACK;
                    end
                end
                WRITEBACK: begin
                    stage_s   = FETCH;
                    pc_s      = next_pc(pc_r, taken_r, offset_r);
                    retired_s = (retired_r == 16'hFFFF) ? retired_r : (retired_r + 16'd1);
                end
                HALT: begin
                    stage_s = HALT;
                end
                default: begin
                    stage_s = FETCH;
                end
            endcase
        end else begin
            stage_s = stage_r;
        end
        stage_en_s = run ? stage_onehot(stage_s) : 5'b00000;
        halted_s   = (stage_s == HALT);
    end

    // State and output registers. Reset discards any latched branch and
    // abandons a pending memory stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_r    <= FETCH;
            pc_r       <= RESET_PC_V;
            retired_r  <= 16'd0;
            taken_r    <= 1'b0;
            offset_r   <= 32'd0;
            stage_en_r <= 5'b00001;
            halted_r   <= 1'b0;
        end else begin
            stage_r    <= stage_s;
            pc_r       <= pc_s;
            retired_r  <= retired_s;
            taken_r    <= taken_s;
            offset_r   <= offset_s;
            stage_en_r <= stage_en_s;
            halted_r   <= halted_s;
        end
    end

    assign pc       = pc_r;
    assign stage    = stage_r;
    assign stage_en = stage_en_r;
    assign halted   = halted_r;
    assign retired  = retired_r;

endmodule

// File: tb/tb_mips_stage_controller.sv
// Testbench for mips_stage_controller.
// The driver walks each instruction through its abstract steps. Inputs are
// randomised on every cycle except where the current step consumes them.
// At the end of each instruction the driver pushes the expected pc, retire
// count and cycle count, computed from plain arithmetic, onto a queue.
// A separate monitor detects the end of each instruction on the DUT side,
// pops the queue and compares. It also checks stage_en and halted on every
// cycle.
module tb_mips_stage_controller;

    localparam int PW  = 4;
    localparam int D   = 9;
    localparam int RPC = 8;

    logic           clock = 1'b0;
    logic           reset;
    logic           run;
    logic           branch;
    logic           zero;
    logic [31:0]    branch_offset;
    logic           end_program;
    logic           mem_read;
    logic           mem_write;
    logic           mem_ready;
    logic [PW-1:0]  pc;
    logic [2:0]     stage;
    logic [4:0]     stage_en;
    logic           halted;
    logic [15:0]    retired;

    typedef struct {
        int pc;
        int ret;
        int cycles;
        bit halt;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_pc     = RPC;
    int   m_ret    = 0;

    mips_stage_controller #(.PC_WIDTH(PW), .IMEM_DEPTH(D), .RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset), .run(run), .branch(branch), .zero(zero),
        .branch_offset(branch_offset), .end_program(end_program),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
        .pc(pc), .stage(stage), .stage_en(stage_en), .halted(halted), .retired(retired)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic rand_inputs();
        run           = 1'($urandom);
        branch        = 1'($urandom);
        zero          = 1'($urandom);
        branch_offset = $urandom;
        end_program   = 1'($urandom);
        mem_read      = 1'($urandom);
        mem_write     = 1'($urandom);
        mem_ready     = 1'($urandom);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic freeze(input int n, inout int cyc);
        for (int i = 0; i < n; i++) begin
            rand_inputs();
            run = 1'b0;
            tick();
            cyc++;
        end
    endtask

    task automatic apply_reset();
        rand_inputs();
        reset = 1'b1;
        sb_q.delete();
        tick();
        reset = 1'b0;
        m_pc  = RPC;
        m_ret = 0;
    endtask

    // Drives one instruction. fz_e adds forced freeze cycles before the
    // EXECUTE edge. rnd_fz enables random freezes before every step.
    task automatic do_instr(input bit endp, input bit br, input bit z, input logic [31:0] off,
                            input bit mr, input bit mw, input int stalls, input int fz_e,
                            input bit rnd_fz);
        int     cyc;
        int     fz[5];
        bit     access;
        bit     skip;
        bit     taken;
        longint s;
        exp_t   e;
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            fz[i] = (rnd_fz && ($urandom_range(0, 5) == 0)) ? int'($urandom_range(1, 3)) : 0;
        end
        fz[2]  = fz[2] + fz_e;
        access = mr | mw;
        freeze(fz[0], cyc);
        rand_inputs(); run = 1'b1; tick(); cyc++;
        freeze(fz[1], cyc);
        rand_inputs(); run = 1'b1; end_program = endp; tick(); cyc++;
        if (endp) begin
            e.pc = m_pc; e.ret = m_ret; e.cycles = cyc; e.halt = 1'b1;
            sb_q.push_back(e);
            return;
        end
        freeze(fz[2], cyc);
        rand_inputs(); run = 1'b1; branch = br; zero = z; branch_offset = off;
        mem_read = mr; mem_write = mw; tick(); cyc++;
`ifdef STAGE_SKIP_EN
        skip = !access;
`else
        skip = 1'b0;
`endif
        if (!skip) begin
            freeze(fz[3], cyc);
            if (access) begin
                for (int i = 0; i < stalls; i++) begin
                    rand_inputs(); run = 1'b1; mem_read = mr; mem_write = mw; mem_ready = 1'b0;
                    tick(); cyc++;
                end
            end
            rand_inputs(); run = 1'b1; mem_read = mr; mem_write = mw;
            if (access) mem_ready = 1'b1;
            tick(); cyc++;
        end
        freeze(fz[4], cyc);
        rand_inputs(); run = 1'b1; tick(); cyc++;
        taken = br & z;
        s = longint'(m_pc) + 1 + (taken ? longint'($signed(off)) : 64'sd0);
        s = s % D;
        if (s < 0) s = s + D;
        m_pc = int'(s);
        if (m_ret < 65535) m_ret++;
        e.pc = m_pc; e.ret = m_ret; e.cycles = cyc; e.halt = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic plain();
        do_instr(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic goto_pc(input int target);
        for (int i = 0; i < D && m_pc != target; i++) plain();
    endtask

    // Monitor: checks per-cycle outputs and scores every instruction end.
    initial begin : monitor
        bit   sync;
        int   prev_stage;
        int   cyc;
        bit   last_run;
        int   halt_pc;
        int   halt_ret;
        exp_t e;
        sync = 1'b0; prev_stage = 0; cyc = 0; last_run = 1'b1; halt_pc = 0; halt_ret = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                sync     = 1'b0;
                last_run = 1'b1;
            end else if (!sync) begin
                sync = 1'b1; prev_stage = 0; cyc = 0;
                check("rst_stage", stage, 0);
                check("rst_pc", pc, RPC);
                check("rst_stage_en", stage_en, 1);
                check("rst_halted", halted, 0);
                check("rst_retired", retired, 0);
                last_run = run;
            end else begin
                cyc++;
                check("stage_en", stage_en, (last_run && stage < 3'd5) ? (1 << stage) : 0);
                check("halted", halted, (stage == 3'd5) ? 1 : 0);
                if ((stage == 3'd0 && prev_stage != 0) || (stage == 3'd5 && prev_stage != 5)) begin
                    check("sb_nonempty", (sb_q.size() > 0) ? 1 : 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("end_is_halt", (stage == 3'd5) ? 1 : 0, e.halt ? 1 : 0);
                        check("pc", pc, e.pc);
                        check("retired", retired, e.ret);
                        check("cycles", cyc, e.cycles);
                        halt_pc  = e.pc;
                        halt_ret = e.ret;
                    end
                    cyc = 0;
                end else if (stage == 3'd5) begin
                    check("halt_pc", pc, halt_pc);
                    check("halt_retired", retired, halt_ret);
                end
                prev_stage = int'(stage);
                last_run   = run;
            end
        end
    end

    initial begin : driver
        int o;
        reset = 1'b1;
        rand_inputs();
        run = 1'b0;
        tick();
        apply_reset();

        // Ten plain instructions: pc 8,0,1,...,8.
        for (int i = 0; i < 10; i++) plain();

        // Load at pc=2 with three not-ready cycles.
        goto_pc(2);
        do_instr(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 3, 0, 1'b0);

        // Branches: +5 from pc=1, -3 from pc=0, then not taken with zero=0.
        goto_pc(1);
        do_instr(1'b0, 1'b1, 1'b1, 32'd5, 1'b0, 1'b0, 0, 0, 1'b0);
        goto_pc(0);
        do_instr(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 0, 0, 1'b0);
        do_instr(1'b0, 1'b1, 1'b0, 32'd5, 1'b0, 1'b0, 0, 0, 1'b0);

        // Six frozen cycles in EXECUTE with a taken branch.
        do_instr(1'b0, 1'b1, 1'b1, 32'd2, 1'b0, 1'b0, 0, 6, 1'b0);

        // Randomised instruction mix.
        for (int i = 0; i < 150; i++) begin
            o = int'($urandom_range(0, 40)) - 20;
            do_instr(1'b0, 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 3) == 0) ? $urandom : 32'(o),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                     int'($urandom_range(0, 3)), 0, 1'b1);
        end

        // Reset while stalled in MEMORY with a taken branch latched.
        goto_pc(5);
        rand_inputs(); run = 1'b1; tick();
        rand_inputs(); run = 1'b1; end_program = 1'b0; tick();
        rand_inputs(); run = 1'b1; branch = 1'b1; zero = 1'b1; branch_offset = 32'd3;
        mem_read = 1'b1; mem_write = 1'b0; tick();
        for (int i = 0; i < 2; i++) begin
            rand_inputs(); run = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_ready = 1'b0; tick();
        end
        apply_reset();
        plain();

        // Halt at pc=4, then toggle everything.
        goto_pc(4);
        do_instr(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            rand_inputs();
            tick();
        end
        apply_reset();
        plain();

        tick(); tick(); tick();
        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
